// File: rtl/cache_pkg.sv
// Shared definitions for the N-way set-associative cache array.
// Holds the access-size encodings, address-field width helpers and the
// load-extend / store-merge helpers used by cache_nway.
package cache_pkg;

  localparam logic [1:0] SZ_BYTE      = 2'd0;
  localparam logic [1:0] SZ_HALF      = 2'd1;
  localparam logic [1:0] SZ_WORD      = 2'd2;
  localparam int         UNSIGNED_BIT = 2;

  // Set index width
  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  // Word-offset width
  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  // Tag width: what remains of a 32-bit byte address
  function automatic int tag_w(input int sets, input int words);
    return 32 - idx_w(sets) - off_w(words) - 2;
  endfunction

  // Way-index width, kept at least one bit so a 1-way build still has a port
  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Pick the addressed byte/half/word and zero- or sign-extend it
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  boff,
                                              input logic [2:0]  ubhw);
    logic [7:0]  b;
    logic [15:0] h;
    logic        uns;
    uns = ubhw[UNSIGNED_BIT];
    b   = word[{boff, 3'b000} +: 8];
    h   = boff[1] ? word[31:16] : word[15:0];
    case (ubhw[1:0])
      SZ_BYTE: load_extend = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_HALF: load_extend = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

  // Merge the low bytes of din into the addressed lanes of old
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] din,
                                              input logic [1:0]  boff,
                                              input logic [1:0]  size);
    logic [31:0] res;
    res = old;
    case (size)
      SZ_BYTE: res[{boff, 3'b000} +: 8] = din[7:0];
      SZ_HALF: begin
        if (boff[1]) res[31:16] = din[15:0];
        else         res[15:0]  = din[15:0];
      end
      default: res = din;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU age tracking for every set of the cache.
// Each way of a set carries an age; 0 is most recent, WAYS-1 least recent.
// The victim is the lowest-index invalid way, else the oldest way.
module cache_lru import cache_pkg::*; #(
  parameter  int WAYS = 2,
  parameter  int SETS = 32,
  localparam int IW   = idx_w(SETS),
  localparam int WW   = way_w(WAYS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IW-1:0]   set_i,
  input  logic            access_i,
  input  logic [WW-1:0]   way_i,
  input  logic [WAYS-1:0] valid_i,
  output logic [WW-1:0]   victim_o
);

  if (WAYS == 1) begin : g_single
    // A direct-mapped array has nothing to choose between
    assign victim_o = '0;
  end else begin : g_multi
    logic [SETS-1:0][WAYS-1:0][WW-1:0] age_q;
    logic [WAYS-1:0][WW-1:0]           age_d;

    // Ages of the indexed set after an access to way_i
    always_comb begin
      age_d = age_q[set_i];
      for (int w = 0; w < WAYS; w++) begin
        if (WW'(w) == way_i)
          age_d[w] = '0;
        else if (age_q[set_i][w] < age_q[set_i][way_i])
          age_d[w] = age_q[set_i][w] + 1'b1;
      end
    end

    // Age storage; reset leaves way i with age i
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++)
            age_q[s][w] <= WW'(w);
      end else if (access_i) begin
        age_q[set_i] <= age_d;
      end
    end

    // Victim: lowest invalid way wins over the oldest way
    always_comb begin
      victim_o = '0;
      for (int w = WAYS - 1; w >= 0; w--)
        if (age_q[set_i][w] == WW'(WAYS - 1)) victim_o = WW'(w);
      for (int w = WAYS - 1; w >= 0; w--)
        if (!valid_i[w]) victim_o = WW'(w);
    end
  end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative data cache array with true-LRU replacement.
// Lookup is combinational; all state changes on the rising clock edge.
// Optional feature: define CACHE_STATS_EN to add saturating hit/miss
// counters (hit_cnt, miss_cnt) for load and store commands.
// SETS and WORDS_PER_LINE are expected to be at least 2.
module cache_nway import cache_pkg::*; #(
  parameter  int WAYS           = 2,
  parameter  int SETS           = 32,
  parameter  int WORDS_PER_LINE = 4,
  localparam int TAG_W          = tag_w(SETS, WORDS_PER_LINE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic             load,
  input  logic             store,
  input  logic             replace,
  input  logic             invalid,
  input  logic [2:0]       u_b_h_w,
  input  logic [31:0]      din,
  output logic             hit,
  output logic [31:0]      dout,
  output logic             valid,
  output logic             dirty,
  output logic [TAG_W-1:0] tag
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]      hit_cnt,
  output logic [31:0]      miss_cnt
`endif
);

  localparam int IW = idx_w(SETS);
  localparam int OW = off_w(WORDS_PER_LINE);
  localparam int WW = way_w(WAYS);

  // Address fields
  logic [TAG_W-1:0] a_tag;
  logic [IW-1:0]    a_idx;
  logic [OW-1:0]    a_off;
  logic [1:0]       a_boff;

  assign a_boff = addr[1:0];
  assign a_off  = addr[2 +: OW];
  assign a_idx  = addr[2 + OW +: IW];
  assign a_tag  = addr[31 -: TAG_W];

  // Line state; data is not reset and is masked by hit
  logic [SETS-1:0][WAYS-1:0]             valid_q, dirty_q;
  logic [SETS-1:0][WAYS-1:0][TAG_W-1:0]  tag_q;
  logic [31:0] data_q [SETS][WAYS][WORDS_PER_LINE];

  logic [WAYS-1:0] valid_d, dirty_d;
  logic            tag_we, data_we, lru_acc;
  logic [31:0]     data_d, rd_word;
  logic [WAYS-1:0] match;
  logic [WW-1:0]   hit_way, victim, sel_way;
  logic            do_inv, do_rep, do_st, do_ld;

  // Tag compare across all ways of the indexed set
  always_comb begin
    match = '0;
    for (int w = 0; w < WAYS; w++)
      match[w] = valid_q[a_idx][w] && (tag_q[a_idx][w] == a_tag);
  end

  // Lowest matching way, should more than one ever match
  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (match[w]) hit_way = WW'(w);
  end

  assign hit     = |match;
  assign sel_way = hit ? hit_way : victim;
  assign rd_word = data_q[a_idx][sel_way][a_off];
  assign valid   = valid_q[a_idx][sel_way];
  assign dirty   = dirty_q[a_idx][sel_way];
  assign tag     = tag_q[a_idx][sel_way];
  assign dout    = hit ? load_extend(rd_word, a_boff, u_b_h_w) : 32'd0;

  // Only the highest-priority command acts
  assign do_inv = invalid;
  assign do_rep = replace & ~invalid;
  assign do_st  = store & ~invalid & ~replace;
  assign do_ld  = load & ~invalid & ~replace & ~store;

  cache_lru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .clk      (clk),
    .rst      (rst),
    .set_i    (a_idx),
    .access_i (lru_acc),
    .way_i    (sel_way),
    .valid_i  (valid_q[a_idx]),
    .victim_o (victim)
  );

  // Next state of the indexed set for the winning command
  always_comb begin
    valid_d = valid_q[a_idx];
    dirty_d = dirty_q[a_idx];
    tag_we  = 1'b0;
    data_we = 1'b0;
    data_d  = rd_word;
    lru_acc = 1'b0;
    if (do_inv) begin
      if (hit) begin
        valid_d[sel_way] = 1'b0;
        dirty_d[sel_way] = 1'b0;
      end
    end else if (do_rep) begin
      data_we = 1'b1;
      data_d  = din;
      lru_acc = 1'b1;
      if (!hit) begin
        valid_d[sel_way] = 1'b1;
        dirty_d[sel_way] = 1'b0;
        tag_we           = 1'b1;
      end
    end else if (do_st) begin
      if (hit) begin
        data_we          = 1'b1;
        data_d           = store_merge(rd_word, din, a_boff, u_b_h_w[1:0]);
        dirty_d[sel_way] = 1'b1;
        lru_acc          = 1'b1;
      end
    end else if (do_ld) begin
      lru_acc = hit;
    end
  end

  // Line state update; reset clears valid/dirty/tag and leaves data alone
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
      tag_q   <= '0;
    end else begin
      valid_q[a_idx] <= valid_d;
      dirty_q[a_idx] <= dirty_d;
      if (tag_we)  tag_q[a_idx][sel_way] <= a_tag;
      if (data_we) data_q[a_idx][sel_way][a_off] <= data_d;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Saturating hit/miss counts for load and store commands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else if (do_ld | do_st) begin
      if (hit) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_nway.sv
// Bench for cache_nway: a 2-way and a 4-way instance share one stimulus
// stream and are each compared against a recency-list reference model.
module tb_cache_nway;

  localparam int TW = 23;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   addr, din;
  logic          load, store, replace, invalid;
  logic [2:0]    ubhw;
  logic          hit2, valid2, dirty2, hit4, valid4, dirty4;
  logic [31:0]   dout2, dout4;
  logic [TW-1:0] tag2, tag4;
`ifdef CACHE_STATS_EN
  logic [31:0]   hc2, mc2, hc4, mc4;
`endif

  always #5 clk = ~clk;

  cache_nway #(.WAYS(2)) u_dut2 (
    .clk(clk), .rst(rst), .addr(addr), .load(load), .store(store),
    .replace(replace), .invalid(invalid), .u_b_h_w(ubhw), .din(din),
    .hit(hit2), .dout(dout2), .valid(valid2), .dirty(dirty2), .tag(tag2)
`ifdef CACHE_STATS_EN
    , .hit_cnt(hc2), .miss_cnt(mc2)
`endif
  );

  cache_nway #(.WAYS(4)) u_dut4 (
    .clk(clk), .rst(rst), .addr(addr), .load(load), .store(store),
    .replace(replace), .invalid(invalid), .u_b_h_w(ubhw), .din(din),
    .hit(hit4), .dout(dout4), .valid(valid4), .dirty(dirty4), .tag(tag4)
`ifdef CACHE_STATS_EN
    , .hit_cnt(hc4), .miss_cnt(mc4)
`endif
  );

  // Reference model: index 0 models the 2-way instance, index 1 the 4-way
  int          nw [2] = '{2, 4};
  bit          m_valid [2][32][4];
  bit          m_dirty [2][32][4];
  int unsigned m_tag   [2][32][4];
  int unsigned m_data  [2][32][4][4];
  bit          m_known [2][32][4][4];
  int          m_rec   [2][32][4];   // recency list, element 0 = most recent
`ifdef CACHE_STATS_EN
  int unsigned m_hits [2], m_miss [2];
`endif

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic int f_set(input logic [31:0] a);  return int'((a >> 4) & 32'h1F); endfunction
  function automatic int f_word(input logic [31:0] a); return int'((a >> 2) & 32'h3);  endfunction
  function automatic int unsigned f_tag(input logic [31:0] a); return a >> 9; endfunction

  function automatic int unsigned tb_ext(input int unsigned w, input int boff, input logic [2:0] sz);
    int unsigned v;
    if (sz[1:0] == 2'd0) begin
      v = (w >> (8 * boff)) & 32'hFF;
      if (!sz[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz[1:0] == 2'd1) begin
      v = (w >> (16 * (boff / 2))) & 32'hFFFF;
      if (!sz[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic int unsigned tb_merge(input int unsigned old, input int unsigned d,
                                           input int boff, input logic [2:0] sz);
    int unsigned mask, val;
    if (sz[1:0] == 2'd0) begin
      mask = 32'hFF << (8 * boff);
      val  = (d & 32'hFF) << (8 * boff);
    end else if (sz[1:0] == 2'd1) begin
      mask = 32'hFFFF << (16 * (boff / 2));
      val  = (d & 32'hFFFF) << (16 * (boff / 2));
    end else begin
      mask = 32'hFFFF_FFFF;
      val  = d;
    end
    return (old & ~mask) | val;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 32; s++)
        for (int w = 0; w < 4; w++) begin
          m_valid[k][s][w] = 1'b0;
          m_dirty[k][s][w] = 1'b0;
          m_tag[k][s][w]   = 0;
          m_rec[k][s][w]   = w;
        end
`ifdef CACHE_STATS_EN
      m_hits[k] = 0;
      m_miss[k] = 0;
`endif
    end
  endtask

  // Hit way, or victim: lowest invalid way, else least recently used
  task automatic model_sel(input int k, output bit h, output int sel);
    int s;
    s   = f_set(addr);
    h   = 1'b0;
    sel = 0;
    for (int w = 0; w < nw[k]; w++)
      if (!h && m_valid[k][s][w] && m_tag[k][s][w] == f_tag(addr)) begin
        h   = 1'b1;
        sel = w;
      end
    if (!h) begin
      sel = m_rec[k][s][nw[k] - 1];
      for (int w = nw[k] - 1; w >= 0; w--)
        if (!m_valid[k][s][w]) sel = w;
    end
  endtask

  task automatic touch(input int k, input int s, input int w);
    int p;
    p = 0;
    for (int i = 0; i < nw[k]; i++)
      if (m_rec[k][s][i] == w) p = i;
    for (int i = p; i > 0; i--)
      m_rec[k][s][i] = m_rec[k][s][i - 1];
    m_rec[k][s][0] = w;
  endtask

  task automatic model_commit(input int k);
    bit h;
    int sel, s, wd;
    model_sel(k, h, sel);
    s  = f_set(addr);
    wd = f_word(addr);
    if (invalid) begin
      if (h) begin
        m_valid[k][s][sel] = 1'b0;
        m_dirty[k][s][sel] = 1'b0;
      end
    end else if (replace) begin
      m_data[k][s][sel][wd]  = din;
      m_known[k][s][sel][wd] = 1'b1;
      if (!h) begin
        m_valid[k][s][sel] = 1'b1;
        m_dirty[k][s][sel] = 1'b0;
        m_tag[k][s][sel]   = f_tag(addr);
      end
      touch(k, s, sel);
    end else if (store) begin
`ifdef CACHE_STATS_EN
      if (h) m_hits[k]++; else m_miss[k]++;
`endif
      if (h) begin
        m_data[k][s][sel][wd] = tb_merge(m_data[k][s][sel][wd], din, int'(addr[1:0]), ubhw);
        if (ubhw[1:0] >= 2'd2) m_known[k][s][sel][wd] = 1'b1;
        m_dirty[k][s][sel] = 1'b1;
        touch(k, s, sel);
      end
    end else if (load) begin
`ifdef CACHE_STATS_EN
      if (h) m_hits[k]++; else m_miss[k]++;
`endif
      if (h) touch(k, s, sel);
    end
  endtask

  task automatic chk_outputs(input string ph);
    bit          h;
    int          sel, s, wd;
    logic        ah, av, ad;
    logic [31:0] at, ado;
    for (int k = 0; k < 2; k++) begin
      model_sel(k, h, sel);
      s  = f_set(addr);
      wd = f_word(addr);
      if (k == 0) begin
        ah = hit2; av = valid2; ad = dirty2; at = 32'(tag2); ado = dout2;
      end else begin
        ah = hit4; av = valid4; ad = dirty4; at = 32'(tag4); ado = dout4;
      end
      check($sformatf("%s_w%0d_hit", ph, nw[k]),   32'(ah), 32'(h));
      check($sformatf("%s_w%0d_valid", ph, nw[k]), 32'(av), 32'(m_valid[k][s][sel]));
      check($sformatf("%s_w%0d_dirty", ph, nw[k]), 32'(ad), 32'(m_dirty[k][s][sel]));
      check($sformatf("%s_w%0d_tag", ph, nw[k]),   at, m_tag[k][s][sel]);
      if (!h)
        check($sformatf("%s_w%0d_dout", ph, nw[k]), ado, 32'd0);
      else if (m_known[k][s][sel][wd])
        check($sformatf("%s_w%0d_dout", ph, nw[k]), ado,
              tb_ext(m_data[k][s][sel][wd], int'(addr[1:0]), ubhw));
`ifdef CACHE_STATS_EN
      check($sformatf("%s_w%0d_hcnt", ph, nw[k]), (k == 0) ? hc2 : hc4, m_hits[k]);
      check($sformatf("%s_w%0d_mcnt", ph, nw[k]), (k == 0) ? mc2 : mc4, m_miss[k]);
`endif
    end
  endtask

  // Drive a command just after the falling edge and check the lookup
  task automatic cyc_begin(input bit ld, input bit st, input bit rp, input bit iv,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] sz, input string ph);
    load = ld; store = st; replace = rp; invalid = iv;
    addr = a; din = d; ubhw = sz;
    #1;
    chk_outputs(ph);
  endtask

  task automatic cyc_end();
    model_commit(0);
    model_commit(1);
    @(negedge clk);
  endtask

  task automatic cyc(input bit ld, input bit st, input bit rp, input bit iv,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] sz, input string ph);
    cyc_begin(ld, st, rp, iv, a, d, sz, ph);
    cyc_end();
  endtask

  // Assert reset part-way through a cycle whose command must be discarded
  task automatic async_reset(input string ph);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk_outputs(ph);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    load = 1'b0; store = 1'b0; replace = 1'b0; invalid = 1'b0;
    addr = '0; din = '0; ubhw = 3'd2;
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < 32; s++)
        for (int w = 0; w < 4; w++)
          for (int i = 0; i < 4; i++) begin
            m_data[k][s][w][i]  = 0;
            m_known[k][s][w][i] = 1'b0;
          end
    model_reset();
    @(negedge clk);
    #1;
    chk_outputs("rst0");
    check("rst0_dout", dout2, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Fill one word, hit on it, hit a stale word, miss another set
    cyc(0, 0, 1, 0, 32'h4, 32'h1234_5678, 3'd2, "t1_fill");
    cyc_begin(1, 0, 0, 0, 32'h4, 32'h0, 3'd2, "t1_ld4");
    check("t1_ld4_hit", 32'(hit2), 32'd1);
    check("t1_ld4_dout", dout2, 32'h1234_5678);
    cyc_end();
    cyc_begin(1, 0, 0, 0, 32'h8, 32'h0, 3'd2, "t1_ld8");
    check("t1_ld8_hit", 32'(hit2), 32'd1);
    cyc_end();
    cyc_begin(1, 0, 0, 0, 32'h20, 32'h0, 3'd2, "t1_ld20");
    check("t1_ld20_hit", 32'(hit2), 32'd0);
    check("t1_ld20_dout", dout2, 32'd0);
    cyc_end();

    // Byte store merge and sized loads
    cyc(0, 0, 1, 0, 32'h10, 32'h3456_8890, 3'd2, "t2_fill");
    cyc(0, 1, 0, 0, 32'h11, 32'h0000_0067, 3'd0, "t2_stb");
    cyc_begin(1, 0, 0, 0, 32'h10, 32'h0, 3'd2, "t2_ldw");
    check("t2_ldw_dout", dout2, 32'h3456_6790);
    check("t2_ldw_dirty", 32'(dirty2), 32'd1);
    cyc_end();
    cyc_begin(1, 0, 0, 0, 32'h11, 32'h0, 3'd0, "t2_ldb");
    check("t2_ldb_dout", dout2, 32'h0000_0067);
    cyc_end();
    cyc_begin(1, 0, 0, 0, 32'h12, 32'h0, 3'd1, "t2_ldh");
    check("t2_ldh_dout", dout2, 32'h0000_3456);
    cyc_end();

    // LRU victim choice in a 2-way set
    async_reset("t3_rst");
    cyc(0, 0, 1, 0, 32'h60,  32'h00A9_8AC7, 3'd2, "t3_f60");
    cyc(0, 0, 1, 0, 32'h260, 32'h01FC_A055, 3'd2, "t3_f260");
    cyc(1, 0, 0, 0, 32'h60,  32'h0, 3'd2, "t3_ld60");
    cyc_begin(1, 0, 0, 0, 32'h460, 32'h0, 3'd2, "t3_ld460");
    check("t3_ld460_hit", 32'(hit2), 32'd0);
    check("t3_ld460_vtag", 32'(tag2), 32'd1);
    cyc_end();
    cyc(0, 0, 1, 0, 32'h460, 32'h0BAD_F00D, 3'd2, "t3_f460");
    cyc_begin(1, 0, 0, 0, 32'h260, 32'h0, 3'd2, "t3_ld260");
    check("t3_ld260_hit", 32'(hit2), 32'd0);
    cyc_end();

    // Invalid way is refilled first in a 4-way set
    async_reset("t4_rst");
    cyc(0, 0, 1, 0, 32'h60,  32'h1, 3'd2, "t4_f60");
    cyc(0, 0, 1, 0, 32'h260, 32'h2, 3'd2, "t4_f260");
    cyc(0, 0, 1, 0, 32'h460, 32'h3, 3'd2, "t4_f460");
    cyc(0, 0, 1, 0, 32'h660, 32'h4, 3'd2, "t4_f660");
    cyc(0, 0, 0, 1, 32'h460, 32'h0, 3'd2, "t4_inv");
    cyc_begin(1, 0, 0, 0, 32'hA60, 32'h0, 3'd2, "t4_ldA60");
    check("t4_vict_valid", 32'(valid4), 32'd0);
    cyc_end();
    cyc(0, 0, 1, 0, 32'hA60, 32'h5, 3'd2, "t4_fA60");
    cyc_begin(1, 0, 0, 0, 32'h60, 32'h0, 3'd2, "t4_ld60");
    check("t4_ld60_hit", 32'(hit4), 32'd1);
    cyc_end();
    cyc_begin(1, 0, 0, 0, 32'h260, 32'h0, 3'd2, "t4_ld260");
    check("t4_ld260_hit", 32'(hit4), 32'd1);
    cyc_end();
    cyc_begin(1, 0, 0, 0, 32'h660, 32'h0, 3'd2, "t4_ld660");
    check("t4_ld660_hit", 32'(hit4), 32'd1);
    cyc_end();
    cyc_begin(1, 0, 0, 0, 32'hA60, 32'h0, 3'd2, "t4_ldA60b");
    check("t4_ldA60_dout", dout4, 32'h5);
    cyc_end();

    // Store and invalid together: invalid wins, data untouched
    async_reset("t5_rst");
    cyc(0, 0, 1, 0, 32'h60, 32'h1111_1111, 3'd2, "t5_fill");
    cyc(0, 1, 0, 0, 32'h60, 32'h2222_2222, 3'd2, "t5_st");
    cyc(0, 1, 0, 1, 32'h60, 32'h3333_3333, 3'd2, "t5_stinv");
    cyc_begin(1, 0, 0, 0, 32'h60, 32'h0, 3'd2, "t5_ld");
    check("t5_ld_hit", 32'(hit2), 32'd0);
    check("t5_ld_dirty", 32'(dirty2), 32'd0);
    cyc_end();
    cyc(0, 0, 1, 0, 32'h64, 32'h4444_4444, 3'd2, "t5_f64");
    cyc_begin(1, 0, 0, 0, 32'h60, 32'h0, 3'd2, "t5_ld60");
    check("t5_ld60_dout", dout2, 32'h2222_2222);
    cyc_end();

    // Reset in the middle of a replace
    cyc(0, 0, 1, 0, 32'h30, 32'h7, 3'd2, "t6_f30");
    cyc_begin(0, 0, 1, 0, 32'h90, 32'h8, 3'd2, "t6_f90");
    async_reset("t6_rst");
    cyc_begin(1, 0, 0, 0, 32'h90, 32'h0, 3'd2, "t6_ld90");
    check("t6_ld90_hit2", 32'(hit2), 32'd0);
    check("t6_ld90_hit4", 32'(hit4), 32'd0);
    cyc_end();

`ifdef CACHE_STATS_EN
    async_reset("t7_rst");
    cyc(0, 0, 1, 0, 32'h60, 32'h9, 3'd2, "t7_fill");
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 32'h60, 32'h0, 3'd2, "t7_ld");
    for (int i = 0; i < 2; i++) cyc(0, 1, 0, 0, 32'h460, 32'h1, 3'd2, "t7_st");
    #1;
    check("t7_hit_cnt", hc2, 32'd3);
    check("t7_miss_cnt", mc2, 32'd2);
`endif

    // Randomized traffic over a few conflicting tags in two sets
    for (int i = 0; i < 800; i++) begin
      logic [31:0] a;
      int unsigned r;
      bit ld, st, rp, iv;
      a = ($urandom_range(0, 5) << 9) | ($urandom_range(0, 1) << 4) |
          ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      r  = $urandom_range(0, 15);
      ld = (r <= 4);
      st = (r >= 5 && r <= 8);
      rp = (r >= 9 && r <= 12);
      iv = (r == 13);
      if (r == 14) begin
        ld = 1'($urandom_range(0, 1)); st = 1'($urandom_range(0, 1));
        rp = 1'($urandom_range(0, 1)); iv = 1'($urandom_range(0, 1));
      end
      cyc_begin(ld, st, rp, iv, a, $urandom, 3'($urandom_range(0, 7)), "rnd");
      if ($urandom_range(0, 79) == 0) async_reset("rnd_rst");
      else cyc_end();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_nway.md
Name: cache_nway

Overview:
Parametrised N-way set-associative data cache array. It is the successor to the fixed 2-way cache, generalised in ways, sets and line length, with true-LRU replacement and invalid-way-first victim selection. Lookup is combinational and state updates happen on the clock edge. An external cache controller FSM drives the commands and handles memory refill and writeback using the valid/dirty/tag reported for the victim way.

Parameters:
WAYS, 2, associativity; power of 2, range 1..8
SETS, 32, number of sets; power of 2
WORDS_PER_LINE, 4, 32-bit words per line; power of 2
TAG_W, 32-log2(SETS)-log2(WORDS_PER_LINE)-2, derived; 23 at defaults; not overridable

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
addr  in  32  byte address; fields are {tag, index, word offset, byte offset}
load  in  1  read access
store  in  1  write access, byte/half/word merge
replace  in  1  line-fill write of one full word
invalid  in  1  invalidate the line matching addr
u_b_h_w  in  3  bit2 = unsigned; [1:0] = 0 byte, 1 half, 2 word (3 is treated as word)
din  in  32  store/fill data
hit  out  1  addr tag matches a valid way in the indexed set
dout  out  32  extended load data; 0 when hit=0
valid  out  1  valid bit of the selected way
dirty  out  1  dirty bit of the selected way
tag  out  TAG_W  stored tag of the selected way

Behaviour:
- Selected way: the hit way when hit=1, otherwise the victim way. hit, dout, valid, dirty and tag are combinational from addr and current state, with no latency.
- Victim way: the lowest-index invalid way in the set; if every way is valid, the way with age WAYS-1.
- Commands: one-hot per cycle. If several are asserted, priority is invalid > replace > store > load; only the winner acts.
- load, hit: dout is the byte/half/word at the address, zero- or sign-extended per u_b_h_w. The hit way becomes MRU. Miss: no state change, dout=0.
- store, hit: only the addressed bytes are merged from din's low bytes; dirty is set; the way becomes MRU. Miss: no state change (no write-allocate).
- Alignment: byte offset bits below the access size are ignored (half uses addr[1], word ignores addr[1:0]).
- replace, hit: the word at the word offset is written with din; valid, tag and dirty are unchanged; the way becomes MRU.
- replace, miss: the victim's word at the offset is written with din; valid=1, the tag is loaded and dirty=0; the victim becomes MRU.
- Filling a line: the first replace allocates and later words of the same line hit. The other words of a newly allocated line are stale until the controller fills them.
- invalid, hit: valid and dirty of the hit way are cleared; LRU is unchanged. Miss: no effect.
- LRU: each set holds WAYS ages of log2(WAYS) bits each. When way w is accessed, its age becomes 0 and every way with age < old age(w) is incremented. Ages always stay a permutation of 0..WAYS-1.
- With WAYS=1 there is no LRU state and the victim is always way 0.
- Reset (async, rst=0, also mid-operation): all valid, dirty and tag bits clear; way i age = i. Data RAM is not reset; it is masked by hit.
- Outputs after reset: hit=0, dout=0, valid=0, dirty=0, tag=0.
- A command coincident with reset assertion is discarded.

Optional Feature:
CACHE_STATS_EN: adds outputs hit_cnt[31:0] and miss_cnt[31:0].
- Each load or store command increments hit_cnt on hit or miss_cnt on miss; replace and invalid are not counted.
- Counters saturate at 32'hFFFFFFFF and reset to 0.
- Without the macro the ports and counters do not exist and the behaviour is otherwise identical.

Decomposition:
- Package cache_pkg: size encodings (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2, UNSIGNED_BIT=2), address-field width functions, and a load-extend function.
- Sub-module cache_lru: per-set age storage, update on access, victim select taking valid bits.
- cache_nway instantiates one cache_lru and holds the tag/valid/dirty/data arrays.

Test Plan:
- Reset, then replace 0x4 with 0x12345678, then load word 0x4: hit=1, dout=0x12345678. Load 0x8: hit=1, dout=stale data RAM contents (0 in simulation). Load 0x20: hit=0, dout=0.
- Store byte 0x67 at 0x11 into the line holding 0x34568890 at 0x10, then load word 0x10: dout=0x34566790, dirty=1. Load signed byte 0x11: 0x00000067. Load signed half 0x12: 0x00003456.
- WAYS=2: replace 0x60 (0x00A98AC7), then 0x260 (0x01FCA055); load 0x60; then load 0x460: hit=0, victim tag = tag of 0x260. Replace 0x460, then load 0x260: miss.
- WAYS=4: fill four same-set lines at 0x60, 0x260, 0x460, 0x660; invalidate 0x460; replace 0xA60: fills the invalidated way; 0x60, 0x260 and 0x660 all still hit.
- Assert store and invalid together on a dirty hit: the line is invalidated, the data is not written, dirty=0. Assert rst low mid-sequence: all hit=0 and the LRU ages return to way index.
- CACHE_STATS_EN: 3 load hits, 2 store misses and 1 replace give hit_cnt=3, miss_cnt=2. A counter preset near max saturates at 0xFFFFFFFF.
